// File: rtl/eth_prbs31_checker.sv
// Clause 49 inverted-PRBS31 checker for 64b/66b blocks: per-block bit-error count and lock tracking.
// Define ETH_PRBS31_CHK_STATS_EN to build the saturating cumulative error total.
module eth_prbs31_checker (
  input  logic        rx_clk,
  input  logic        rx_rst,
  input  logic [63:0] serdes_rx_data,
  input  logic [1:0]  serdes_rx_hdr,
  input  logic        serdes_rx_valid,
  input  logic        cfg_rx_prbs31_enable,
  input  logic        cfg_stats_clear,
  output logic [6:0]  rx_error_count,
  output logic        rx_prbs_lock,
  output logic [31:0] rx_bit_err_total
);

  localparam int unsigned BLK_W    = 66;
  localparam int unsigned LFSR_W   = 31;
  localparam int unsigned CNT_W    = 7;
  localparam int unsigned TOT_W    = 32;
  localparam int unsigned SUM_W    = TOT_W + 1;
  localparam int unsigned GOOD_W   = 4;
  localparam int unsigned BAD_W    = 3;
  localparam int unsigned GOOD_MAX = 8;
  localparam int unsigned BAD_MAX  = 4;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SEED     = 2'd1,
    ST_CHECK    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [BAD_W-1:0]    bad_q, bad_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                lock_q, lock_d;

  logic [BLK_W-1:0]    blk;
  logic [LFSR_W-1:0]   walk_s;
  logic [CNT_W-1:0]    walk_err;
  logic                rx_bit;
  logic                pred_bit;

  // Unrolled 66-step predictor walk; line order is hdr[0], hdr[1], data[0..63].
  always_comb begin
    blk      = {serdes_rx_data, serdes_rx_hdr};
    walk_s   = lfsr_q;
    walk_err = '0;
    rx_bit   = 1'b0;
    pred_bit = 1'b0;
    for (int i = 0; i < BLK_W; i++) begin
      rx_bit   = ~blk[i];
      pred_bit = walk_s[LFSR_W-1] ^ walk_s[LFSR_W-4];
      walk_err = walk_err + CNT_W'(rx_bit ^ pred_bit);
      walk_s   = {walk_s[LFSR_W-2:0], rx_bit};
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    good_d    = good_q;
    bad_d     = bad_q;
    err_cnt_d = err_cnt_q;
    lock_d    = lock_q;
    if (!cfg_rx_prbs31_enable) begin
      state_d   = ST_DISABLED;
      lfsr_d    = '0;
      good_d    = '0;
      bad_d     = '0;
      err_cnt_d = '0;
      lock_d    = 1'b0;
    end else begin
      case (state_q)
        ST_DISABLED: state_d = ST_SEED;
        ST_SEED: begin
          if (serdes_rx_valid) begin
            lfsr_d    = walk_s;
            err_cnt_d = '0;
            state_d   = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (serdes_rx_valid) begin
            lfsr_d    = walk_s;
            err_cnt_d = walk_err;
            if (walk_err == '0) begin
              bad_d = '0;
              if (good_q != GOOD_W'(GOOD_MAX)) good_d = good_q + GOOD_W'(1);
              if (good_d == GOOD_W'(GOOD_MAX)) lock_d = 1'b1;
            end else begin
              good_d = '0;
              if (bad_q != BAD_W'(BAD_MAX)) bad_d = bad_q + BAD_W'(1);
              if (bad_d == BAD_W'(BAD_MAX)) lock_d = 1'b0;
            end
          end
        end
        default: state_d = ST_DISABLED;
      endcase
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q   <= ST_DISABLED;
      lfsr_q    <= '0;
      good_q    <= '0;
      bad_q     <= '0;
      err_cnt_q <= '0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      err_cnt_q <= err_cnt_d;
      lock_q    <= lock_d;
    end
  end

  assign rx_error_count = err_cnt_q;
  assign rx_prbs_lock   = lock_q;

`ifdef ETH_PRBS31_CHK_STATS_EN
  logic [TOT_W-1:0] rx_bit_err_total_q, rx_bit_err_total_d;
  logic [TOT_W-1:0] tot_base;
  logic [SUM_W-1:0] tot_sum;

  // Clear applies first so a same-cycle counted block leaves exactly its own count.
  always_comb begin
    tot_base           = cfg_stats_clear ? '0 : rx_bit_err_total_q;
    tot_sum            = {1'b0, tot_base} + SUM_W'(walk_err);
    rx_bit_err_total_d = tot_base;
    if (cfg_rx_prbs31_enable && serdes_rx_valid && (state_q == ST_CHECK)) begin
      rx_bit_err_total_d = tot_sum[SUM_W-1] ? '1 : tot_sum[TOT_W-1:0];
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) rx_bit_err_total_q <= '0;
    else        rx_bit_err_total_q <= rx_bit_err_total_d;
  end

  assign rx_bit_err_total = rx_bit_err_total_q;
`else
  logic unused_stats_clear;
  assign unused_stats_clear = cfg_stats_clear;
  assign rx_bit_err_total   = '0;
`endif

endmodule

// File: tb/tb_eth_prbs31_checker.sv
// Bench for eth_prbs31_checker: PRBS31 line generator drives blocks, expectations queued per block.
`timescale 1ns/1ps
module tb_eth_prbs31_checker;

  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic [63:0] serdes_rx_data;
  logic [1:0]  serdes_rx_hdr;
  logic        serdes_rx_valid;
  logic        cfg_rx_prbs31_enable;
  logic        cfg_stats_clear;
  logic [6:0]  rx_error_count;
  logic        rx_prbs_lock;
  logic [31:0] rx_bit_err_total;

`ifdef ETH_PRBS31_CHK_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  typedef struct {
    logic [6:0]  cnt;
    logic        lock;
    logic [31:0] tot;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_bad    = 0;
  logic [30:0] gen_s    = 31'h5A5A_1234;
  logic [31:0] exp_tot  = '0;

  always #5 rx_clk = ~rx_clk;

  eth_prbs31_checker dut (
    .rx_clk               (rx_clk),
    .rx_rst               (rx_rst),
    .serdes_rx_data       (serdes_rx_data),
    .serdes_rx_hdr        (serdes_rx_hdr),
    .serdes_rx_valid      (serdes_rx_valid),
    .cfg_rx_prbs31_enable (cfg_rx_prbs31_enable),
    .cfg_stats_clear      (cfg_stats_clear),
    .rx_error_count       (rx_error_count),
    .rx_prbs_lock         (rx_prbs_lock),
    .rx_bit_err_total     (rx_bit_err_total)
  );

  // Each queued block is due one edge after it was driven.
  always @(posedge rx_clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (rx_error_count !== mon_e.cnt) begin
        n_bad++;
        $display("FAIL %s rx_error_count got=%0d exp=%0d", mon_e.tag, rx_error_count, mon_e.cnt);
      end
      n_checks++;
      if (rx_prbs_lock !== mon_e.lock) begin
        n_bad++;
        $display("FAIL %s rx_prbs_lock got=%0b exp=%0b", mon_e.tag, rx_prbs_lock, mon_e.lock);
      end
      n_checks++;
      if (rx_bit_err_total !== mon_e.tot) begin
        n_bad++;
        $display("FAIL %s rx_bit_err_total got=%0h exp=%0h", mon_e.tag, rx_bit_err_total, mon_e.tot);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] sat_add(input logic [31:0] a, input int b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Errors when an all-zero block replaces stream bits p while the predictor is in sync.
  function automatic int zero_first_cnt(input logic [65:0] p);
    int c = 35;
    for (int k = 0; k < 28; k++) if (!p[k]) c++;
    for (int k = 28; k < 31; k++) if (p[k] ^ p[k-28]) c++;
    return c;
  endfunction

  // Errors of the first clean block p after the predictor was filled with ones.
  function automatic int resume_cnt(input logic [65:0] p);
    int c = 0;
    for (int k = 0; k < 28; k++) if (p[k]) c++;
    for (int k = 28; k < 31; k++) if (p[k] == p[k-28]) c++;
    return c;
  endfunction

  task automatic gen_block(output logic [63:0] d, output logic [1:0] h, output logic [65:0] p);
    logic nb;
    for (int i = 0; i < 66; i++) begin
      nb    = gen_s[30] ^ gen_s[27];
      gen_s = {gen_s[29:0], nb};
      p[i]  = nb;
    end
    {d, h} = ~p;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [1:0] h, input logic en,
                       input logic clr, input bit push, input int cnt, input logic lk,
                       input bit counted, input string tag);
    exp_t e;
    @(posedge rx_clk);
    #2;
    serdes_rx_valid      = v;
    serdes_rx_data       = d;
    serdes_rx_hdr        = h;
    cfg_rx_prbs31_enable = en;
    cfg_stats_clear      = clr;
    if (STATS_EN) begin
      if (clr) exp_tot = '0;
      if (counted) exp_tot = sat_add(exp_tot, cnt);
    end
    if (push) begin
      e.cnt  = 7'(cnt);
      e.lock = lk;
      e.tot  = exp_tot;
      e.tag  = tag;
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [1:0] h, input int cnt, input logic lk,
                      input bit counted, input logic clr, input string tag);
    drive(1'b1, d, h, 1'b1, clr, 1'b1, cnt, lk, counted, tag);
  endtask

  task automatic test_reset();
    logic [63:0] d; logic [1:0] h; logic [65:0] p;
    rx_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      gen_block(d, h, p);
      drive(1'b1, d, h, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, "rst");
    end
    @(posedge rx_clk); #1;
    n_checks++;
    if (rx_error_count !== 7'd0) begin n_bad++; $display("FAIL reset count got=%0d exp=0", rx_error_count); end
    n_checks++;
    if (rx_prbs_lock !== 1'b0) begin n_bad++; $display("FAIL reset lock got=%0b exp=0", rx_prbs_lock); end
    n_checks++;
    if (rx_bit_err_total !== 32'd0) begin n_bad++; $display("FAIL reset total got=%0h exp=0", rx_bit_err_total); end
    serdes_rx_valid = 1'b0; cfg_rx_prbs31_enable = 1'b0; cfg_stats_clear = 1'b0; rx_rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "idle");
  endtask

  task automatic test_lock();
    logic [63:0] d; logic [1:0] h; logic [65:0] p;
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, "idle");
    gen_block(d, h, p);
    send(d, h, 0, 1'b0, 1'b0, 1'b0, "lock_seed");
    for (int i = 1; i <= 9; i++) begin
      gen_block(d, h, p);
      send(d, h, 0, (i >= 8), 1'b1, 1'b0, "lock_clean");
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, "idle");
    @(posedge rx_clk); #1;
    n_checks++;
    if (rx_prbs_lock !== 1'b1 || rx_error_count !== 7'd0) begin
      n_bad++;
      $display("FAIL lock_hold lock=%0b count=%0d exp lock=1 count=0", rx_prbs_lock, rx_error_count);
    end
  endtask

  task automatic test_bit_flip();
    logic [63:0] d; logic [1:0] h; logic [65:0] p;
    gen_block(d, h, p); d[10] = ~d[10];
    send(d, h, 3, 1'b1, 1'b1, 1'b1, "flip_d10_clr");
    gen_block(d, h, p);
    send(d, h, 0, 1'b1, 1'b1, 1'b0, "flip_after");
    gen_block(d, h, p); h[0] = ~h[0];
    send(d, h, 3, 1'b1, 1'b1, 1'b0, "flip_h0");
    gen_block(d, h, p); d[50] = ~d[50];
    send(d, h, 1, 1'b1, 1'b1, 1'b0, "flip_d50");
    gen_block(d, h, p);
    send(d, h, 2, 1'b1, 1'b1, 1'b0, "flip_d50_echo");
    gen_block(d, h, p);
    send(d, h, 0, 1'b1, 1'b1, 1'b0, "flip_clean");
  endtask

  task automatic test_lock_loss();
    logic [63:0] d; logic [1:0] h; logic [65:0] p;
    int c; int good;
    for (int j = 0; j < 4; j++) begin
      gen_block(d, h, p);
      c = (j == 0) ? zero_first_cnt(p) : 66;
      send('0, '0, c, (j < 3), 1'b1, 1'b0, "loss_zero");
    end
    good = 0;
    for (int j = 0; j < 10; j++) begin
      gen_block(d, h, p);
      c = (j == 0) ? resume_cnt(p) : 0;
      good = (c == 0) ? good + 1 : 0;
      send(d, h, c, (good >= 8), 1'b1, 1'b0, "relock");
    end
  endtask

  task automatic test_enable_drop();
    logic [63:0] d; logic [1:0] h; logic [65:0] p;
    gen_block(d, h, p);
    drive(1'b1, d, h, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "en_drop");
    @(posedge rx_clk); #1;
    n_checks++;
    if (rx_prbs_lock !== 1'b0 || rx_error_count !== 7'd0) begin
      n_bad++;
      $display("FAIL en_drop lock=%0b count=%0d exp lock=0 count=0", rx_prbs_lock, rx_error_count);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, "idle");
    gen_block(d, h, p);
    send(d, h, 0, 1'b0, 1'b0, 1'b0, "en_seed");
    for (int i = 1; i <= 8; i++) begin
      gen_block(d, h, p);
      send(d, h, 0, (i == 8), 1'b1, 1'b0, "en_relock");
    end
  endtask

  task automatic test_reset_midrun();
    logic [63:0] d; logic [1:0] h; logic [65:0] p;
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, "idle");
    rx_rst = 1'b1;
    gen_block(d, h, p);
    drive(1'b1, d, h, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, "rst_mid");
    exp_tot = '0;
    @(posedge rx_clk); #1;
    n_checks++;
    if (rx_prbs_lock !== 1'b0 || rx_error_count !== 7'd0 || rx_bit_err_total !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_mid lock=%0b count=%0d total=%0h exp all zero", rx_prbs_lock, rx_error_count, rx_bit_err_total);
    end
    serdes_rx_valid = 1'b0; rx_rst = 1'b0;
    send('0, '0, 0, 1'b0, 1'b0, 1'b0, "rst_seed_zero");
    send('0, '0, 66, 1'b0, 1'b1, 1'b0, "rst_zero");
  endtask

  task automatic test_all_zero();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, "zero_off");
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, "idle");
    send('0, '0, 0, 1'b0, 1'b0, 1'b0, "zero_seed");
    for (int i = 0; i < 4; i++) send('0, '0, 66, 1'b0, 1'b1, 1'b0, "zero_blk");
  endtask

  task automatic test_stats();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, "idle");
`ifdef ETH_PRBS31_CHK_STATS_EN
    #1;
    force dut.rx_bit_err_total_q = 32'hFFFF_FFC0;
    #1;
    release dut.rx_bit_err_total_q;
    exp_tot = 32'hFFFF_FFC0;
`endif
    send('0, '0, 66, 1'b0, 1'b1, 1'b0, "sat_1");
    send('0, '0, 66, 1'b0, 1'b1, 1'b0, "sat_2");
    send('0, '0, 66, 1'b0, 1'b1, 1'b1, "clr_with_blk");
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, "clr_idle");
    @(posedge rx_clk); #1;
    n_checks++;
    if (rx_bit_err_total !== exp_tot) begin
      n_bad++;
      $display("FAIL clr_idle total got=%0h exp=%0h", rx_bit_err_total, exp_tot);
    end
  endtask

  initial begin
    rx_rst = 1'b1;
    serdes_rx_valid = 1'b0;
    serdes_rx_data = '0;
    serdes_rx_hdr = '0;
    cfg_rx_prbs31_enable = 1'b0;
    cfg_stats_clear = 1'b0;
    test_reset();
    test_lock();
    test_bit_flip();
    test_lock_loss();
    test_enable_drop();
    test_reset_midrun();
    test_all_zero();
    test_stats();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, "idle");
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, "idle");
    n_checks++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
